// File: rtl/bsg_manycore_host_timer_decoder.sv
// Host-side decoder: rebuilds 64-bit timestamps from timer beat pairs into a small FIFO, and forwards all other beats.
// Optional macro BSG_MANYCORE_HOST_TIMER_DECODER_DELTA_EN adds a per-entry delta to the previous timestamp.
module bsg_manycore_host_timer_decoder #(
    parameter int unsigned x_cord_width_p = 4,
    parameter int unsigned y_cord_width_p = 4,
    parameter int unsigned addr_width_p   = 16,
    parameter int unsigned data_width_p   = 32,
    parameter logic [addr_width_p-1:0] timer_addr_p = addr_width_p'(16'h3AB5),
    parameter int unsigned ts_els_p       = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          v_i,
    output logic                          ready_o,
    input  logic [data_width_p-1:0]       data_i,
    input  logic [(data_width_p>>3)-1:0]  mask_i,
    input  logic [addr_width_p-1:0]       addr_i,
    input  logic                          we_i,
    input  logic [x_cord_width_p-1:0]     src_x_cord_i,
    input  logic [y_cord_width_p-1:0]     src_y_cord_i,
    output logic                          v_o,
    input  logic                          ready_i,
    output logic [data_width_p-1:0]       data_o,
    output logic [(data_width_p>>3)-1:0]  mask_o,
    output logic [addr_width_p-1:0]       addr_o,
    output logic                          we_o,
    output logic [x_cord_width_p-1:0]     src_x_cord_o,
    output logic [y_cord_width_p-1:0]     src_y_cord_o,
    output logic                          ts_v_o,
    input  logic                          ts_yumi_i,
    output logic [63:0]                   ts_o,
    output logic [x_cord_width_p-1:0]     ts_x_cord_o,
    output logic [y_cord_width_p-1:0]     ts_y_cord_o,
    output logic                          err_o
`ifdef BSG_MANYCORE_HOST_TIMER_DECODER_DELTA_EN
    ,output logic [63:0]                  ts_delta_o
`endif
);

    localparam int unsigned cnt_w_lp = $clog2(ts_els_p + 1);
    localparam int unsigned ptr_w_lp = $clog2(ts_els_p);

    if (data_width_p < 32) begin : g_bad_data_width
        $error("data_width_p must be >= 32");
    end
    if (ts_els_p < 2) begin : g_bad_ts_els
        $error("ts_els_p must be >= 2");
    end

    typedef enum logic [0:0] {IDLE = 1'b0, WAIT_HI = 1'b1} state_e;

    state_e                      state_q, state_d;
    logic                        err_q, err_d;
    logic                        byp_v_q, byp_v_d;
    logic [cnt_w_lp-1:0]         count_q, count_d;
    logic [ptr_w_lp-1:0]         rptr_q, rptr_d, wptr_q, wptr_d;
    logic [31:0]                 lo_q;
    logic [x_cord_width_p-1:0]   lo_x_q;
    logic [y_cord_width_p-1:0]   lo_y_q;

    logic [63:0]                 ts_mem_q [ts_els_p];
    logic [x_cord_width_p-1:0]   x_mem_q  [ts_els_p];
    logic [y_cord_width_p-1:0]   y_mem_q  [ts_els_p];

    logic is_timer_c, src_match_c, accept_c, ts_full_c, pop_c;
    logic push_c, lo_ld_c, byp_ld_c;
    logic [63:0] ts_new_c;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(ts_els_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    assign is_timer_c  = (addr_i == timer_addr_p) & we_i & (&mask_i);
    assign src_match_c = (src_x_cord_i == lo_x_q) & (src_y_cord_i == lo_y_q);
    assign ts_full_c   = (count_q == cnt_w_lp'(ts_els_p));
    assign ready_o     = ~ts_full_c & (~byp_v_q | ready_i);
    assign accept_c    = v_i & ready_o;
    assign ts_v_o      = (count_q != '0);
    assign pop_c       = ts_yumi_i & ts_v_o;
    assign ts_new_c    = {data_i[31:0], lo_q};

    // A beat that breaks a pending pair flags an error, then is handled as if in IDLE
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        push_c   = 1'b0;
        lo_ld_c  = 1'b0;
        byp_ld_c = 1'b0;
        if (accept_c) begin
            if (state_q == WAIT_HI && is_timer_c && src_match_c) begin
                push_c  = 1'b1;
                state_d = IDLE;
            end else begin
                if (state_q == WAIT_HI) err_d = 1'b1;
                if (is_timer_c) begin
                    lo_ld_c = 1'b1;
                    state_d = WAIT_HI;
                end else begin
                    byp_ld_c = 1'b1;
                    state_d  = IDLE;
                end
            end
        end
    end

    always_comb begin
        byp_v_d = byp_ld_c | (byp_v_q & ~ready_i);
        count_d = count_q;
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + cnt_w_lp'(1);
            2'b01:   count_d = count_q - cnt_w_lp'(1);
            default: count_d = count_q;
        endcase
        wptr_d = push_c ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop_c  ? ptr_inc(rptr_q) : rptr_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            err_q        <= 1'b0;
            byp_v_q      <= 1'b0;
            count_q      <= '0;
            rptr_q       <= '0;
            wptr_q       <= '0;
            lo_q         <= '0;
            lo_x_q       <= '0;
            lo_y_q       <= '0;
            data_o       <= '0;
            mask_o       <= '0;
            addr_o       <= '0;
            we_o         <= 1'b0;
            src_x_cord_o <= '0;
            src_y_cord_o <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            byp_v_q <= byp_v_d;
            count_q <= count_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            if (lo_ld_c) begin
                lo_q   <= data_i[31:0];
                lo_x_q <= src_x_cord_i;
                lo_y_q <= src_y_cord_i;
            end
            if (byp_ld_c) begin
                data_o       <= data_i;
                mask_o       <= mask_i;
                addr_o       <= addr_i;
                we_o         <= we_i;
                src_x_cord_o <= src_x_cord_i;
                src_y_cord_o <= src_y_cord_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_c) begin
            ts_mem_q[wptr_q] <= ts_new_c;
            x_mem_q[wptr_q]  <= lo_x_q;
            y_mem_q[wptr_q]  <= lo_y_q;
        end
    end

    assign v_o         = byp_v_q;
    assign err_o       = err_q;
    assign ts_o        = ts_mem_q[rptr_q];
    assign ts_x_cord_o = x_mem_q[rptr_q];
    assign ts_y_cord_o = y_mem_q[rptr_q];

`ifdef BSG_MANYCORE_HOST_TIMER_DECODER_DELTA_EN
    logic [63:0] prev_q;
    logic        seen_q;
    logic [63:0] delta_c;
    logic [63:0] delta_mem_q [ts_els_p];

    // The first push after reset has no predecessor and records a zero delta
    assign delta_c = seen_q ? (ts_new_c - prev_q) : 64'd0;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            prev_q <= '0;
            seen_q <= 1'b0;
        end else if (push_c) begin
            prev_q <= ts_new_c;
            seen_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_c) delta_mem_q[wptr_q] <= delta_c;
    end

    assign ts_delta_o = delta_mem_q[rptr_q];
`endif

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(ts_yumi_i && !ts_v_o))
                else $error("ts_yumi_i asserted while timestamp FIFO empty");
        end
    end
`endif

endmodule

// File: tb/tb_bsg_manycore_host_timer_decoder.sv
// Directed bench for bsg_manycore_host_timer_decoder with scoreboard queues for bypass beats and timestamps.
module tb_bsg_manycore_host_timer_decoder;

    localparam logic [15:0] TA = 16'h3AB5;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  m;
        logic [15:0] a;
        logic        we;
        logic [3:0]  x;
        logic [3:0]  y;
    } byp_t;

    typedef struct packed {
        logic [63:0] ts;
        logic [63:0] delta;
        logic [3:0]  x;
        logic [3:0]  y;
    } ts_t;

    logic        clk, reset_i;
    logic        v_i, ready_o, we_i, v_o, ready_i, we_o, ts_v_o, ts_yumi_i, err_o;
    logic [31:0] data_i, data_o;
    logic [3:0]  mask_i, mask_o;
    logic [15:0] addr_i, addr_o;
    logic [3:0]  src_x_cord_i, src_y_cord_i, src_x_cord_o, src_y_cord_o;
    logic [63:0] ts_o;
    logic [3:0]  ts_x_cord_o, ts_y_cord_o;
`ifdef BSG_MANYCORE_HOST_TIMER_DECODER_DELTA_EN
    logic [63:0] ts_delta_o;
`endif

    int checks = 0;
    int errors = 0;
    byp_t byp_q[$];
    ts_t  ts_q[$];
    logic        m_first;
    logic [63:0] m_prev;
    byp_t mb;
    ts_t  mt;

    bsg_manycore_host_timer_decoder #(
        .x_cord_width_p(4), .y_cord_width_p(4), .addr_width_p(16),
        .data_width_p(32), .timer_addr_p(TA), .ts_els_p(4)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
        .data_i(data_i), .mask_i(mask_i), .addr_i(addr_i), .we_i(we_i),
        .src_x_cord_i(src_x_cord_i), .src_y_cord_i(src_y_cord_i),
        .v_o(v_o), .ready_i(ready_i), .data_o(data_o), .mask_o(mask_o),
        .addr_o(addr_o), .we_o(we_o), .src_x_cord_o(src_x_cord_o),
        .src_y_cord_o(src_y_cord_o), .ts_v_o(ts_v_o), .ts_yumi_i(ts_yumi_i),
        .ts_o(ts_o), .ts_x_cord_o(ts_x_cord_o), .ts_y_cord_o(ts_y_cord_o),
        .err_o(err_o)
`ifdef BSG_MANYCORE_HOST_TIMER_DECODER_DELTA_EN
        , .ts_delta_o(ts_delta_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Scoreboard: compare on every completed handshake
    always @(negedge clk) begin
        if (!reset_i) begin
            if (v_o && ready_i) begin
                if (byp_q.size() == 0) chk("byp_unexpected", 64'(byp_q.size()), 64'd1);
                else begin
                    mb = byp_q.pop_front();
                    chk("byp_beat", 64'({data_o, mask_o, addr_o, we_o, src_x_cord_o, src_y_cord_o}), 64'(mb));
                end
            end
            if (ts_v_o && ts_yumi_i) begin
                if (ts_q.size() == 0) chk("ts_unexpected", 64'(ts_q.size()), 64'd1);
                else begin
                    mt = ts_q.pop_front();
                    chk("ts_value", ts_o, mt.ts);
                    chk("ts_src", 64'({ts_x_cord_o, ts_y_cord_o}), 64'({mt.x, mt.y}));
`ifdef BSG_MANYCORE_HOST_TIMER_DECODER_DELTA_EN
                    chk("ts_delta", ts_delta_o, mt.delta);
`endif
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic send(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m,
                        input logic we, input logic [3:0] x, input logic [3:0] y);
        logic acc;
        int   n;
        acc = 1'b0;
        n = 0;
        v_i = 1'b1; addr_i = a; data_i = d; mask_i = m; we_i = we;
        src_x_cord_i = x; src_y_cord_i = y;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = ready_o;
            @(posedge clk);
            #1;
            n++;
        end
        v_i = 1'b0;
        chk("send_accept", 64'(acc), 64'd1);
    endtask

    task automatic timer(input logic [31:0] d, input logic [3:0] x, input logic [3:0] y);
        send(TA, d, 4'hF, 1'b1, x, y);
    endtask

    task automatic bypass(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m,
                          input logic we, input logic [3:0] x, input logic [3:0] y);
        byp_t b;
        b = '{d: d, m: m, a: a, we: we, x: x, y: y};
        byp_q.push_back(b);
        send(a, d, m, we, x, y);
    endtask

    task automatic push_ts(input logic [63:0] ts, input logic [3:0] x, input logic [3:0] y);
        ts_t e;
        e.ts = ts;
        e.delta = m_first ? 64'd0 : ts - m_prev;
        e.x = x;
        e.y = y;
        m_first = 1'b0;
        m_prev = ts;
        ts_q.push_back(e);
    endtask

    task automatic pop_one();
        ts_yumi_i = 1'b1;
        @(posedge clk);
        #1;
        ts_yumi_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        m_first = 1'b1;
        m_prev = '0;
        idle(2);
        reset_i = 1'b0;
    endtask

    initial begin
        time t0;
        v_i = 0; data_i = '0; mask_i = '0; addr_i = '0; we_i = 0;
        src_x_cord_i = '0; src_y_cord_i = '0; ready_i = 0; ts_yumi_i = 0;
        reset_i = 1'b1;
        m_first = 1'b1;
        m_prev = '0;
        idle(2);
        chk("rst_v_o", 64'(v_o), 64'd0);
        chk("rst_ts_v_o", 64'(ts_v_o), 64'd0);
        chk("rst_err_o", 64'(err_o), 64'd0);
        chk("rst_data_o", 64'(data_o), 64'd0);
        chk("rst_ready_o", 64'(ready_o), 64'd1);
        reset_i = 1'b0;

        // Reassembly
        ready_i = 1'b1;
        timer(32'h0000_0010, 4'd2, 4'd3);
        chk("lo_ts_v_o", 64'(ts_v_o), 64'd0);
        push_ts(64'h0000_0001_0000_0010, 4'd2, 4'd3);
        timer(32'h0000_0001, 4'd2, 4'd3);
        chk("hi_ts_v_o", 64'(ts_v_o), 64'd1);
        chk("hi_v_o", 64'(v_o), 64'd0);
        pop_one();
        chk("pop_ts_v_o", 64'(ts_v_o), 64'd0);

        // Bypass and throughput
        bypass(16'h0100, 32'hDEAD_BEEF, 4'hF, 1'b1, 4'd1, 4'd1);
        chk("byp_v_o", 64'(v_o), 64'd1);
        t0 = $time;
        for (int i = 0; i < 4; i++) begin
            bypass(16'h0200 + 16'(i), 32'h1000 * 32'(i + 1), 4'hF, 1'b1, 4'(i), 4'(i + 1));
            chk("b2b_v_o", 64'(v_o), 64'd1);
        end
        chk("b2b_time", 64'($time - t0), 64'd40);
        bypass(TA, 32'hCAFE_0001, 4'hF, 1'b0, 4'd2, 4'd3);
        bypass(TA, 32'hCAFE_0002, 4'h7, 1'b1, 4'd2, 4'd3);
        chk("near_timer_ts_v_o", 64'(ts_v_o), 64'd0);
        idle(1);
        ready_i = 1'b0;
        bypass(16'h0300, 32'h0BAD_F00D, 4'h3, 1'b1, 4'd4, 4'd5);
        chk("stall_ready_o", 64'(ready_o), 64'd0);
        idle(2);
        chk("stall_hold_v_o", 64'(v_o), 64'd1);
        ready_i = 1'b1;
        idle(1);
        chk("drain_v_o", 64'(v_o), 64'd0);

        // Full FIFO
        for (int i = 0; i < 4; i++) begin
            timer(32'hA0 + 32'(i), 4'd5, 4'd6);
            push_ts({32'(i + 1), 32'hA0 + 32'(i)}, 4'd5, 4'd6);
            timer(32'(i + 1), 4'd5, 4'd6);
        end
        chk("full_ready_o", 64'(ready_o), 64'd0);
        v_i = 1'b1; addr_i = TA; data_i = 32'hB0; mask_i = 4'hF; we_i = 1'b1;
        src_x_cord_i = 4'd5; src_y_cord_i = 4'd6;
        idle(3);
        chk("full_stall_ready_o", 64'(ready_o), 64'd0);
        v_i = 1'b0;
        pop_one();
        chk("after_pop_ready_o", 64'(ready_o), 64'd1);
        timer(32'hB0, 4'd5, 4'd6);
        push_ts({32'h9, 32'hB0}, 4'd5, 4'd6);
        timer(32'h9, 4'd5, 4'd6);
        chk("refull_ready_o", 64'(ready_o), 64'd0);
        repeat (4) pop_one();
        chk("empty_ts_v_o", 64'(ts_v_o), 64'd0);

        // Protocol error
        chk("pre_err_o", 64'(err_o), 64'd0);
        timer(32'h5, 4'd1, 4'd1);
        bypass(16'h0100, 32'h1234_5678, 4'hF, 1'b1, 4'd1, 4'd1);
        chk("err_set", 64'(err_o), 64'd1);
        chk("err_byp_v_o", 64'(v_o), 64'd1);
        idle(3);
        chk("err_sticky", 64'(err_o), 64'd1);
        chk("err_no_ts", 64'(ts_v_o), 64'd0);
        timer(32'h11, 4'd1, 4'd1);
        timer(32'h22, 4'd2, 4'd2);
        chk("xsrc_no_ts", 64'(ts_v_o), 64'd0);
        push_ts({32'h33, 32'h22}, 4'd2, 4'd2);
        timer(32'h33, 4'd2, 4'd2);
        chk("xsrc_ts_v_o", 64'(ts_v_o), 64'd1);
        pop_one();

        // Asynchronous reset mid-operation
        for (int i = 0; i < 2; i++) begin
            timer(32'(2 * i + 1), 4'd7, 4'd7);
            timer(32'(2 * i + 2), 4'd7, 4'd7);
        end
        timer(32'h5, 4'd7, 4'd7);
        chk("prerst_ts_v_o", 64'(ts_v_o), 64'd1);
        #2;
        reset_i = 1'b1;
        m_first = 1'b1;
        m_prev = '0;
        #1;
        chk("arst_ts_v_o", 64'(ts_v_o), 64'd0);
        chk("arst_v_o", 64'(v_o), 64'd0);
        chk("arst_err_o", 64'(err_o), 64'd0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        timer(32'h77, 4'd7, 4'd7);
        chk("postrst_lo_ts_v_o", 64'(ts_v_o), 64'd0);
        push_ts({32'h88, 32'h77}, 4'd7, 4'd7);
        timer(32'h88, 4'd7, 4'd7);
        chk("postrst_ts_v_o", 64'(ts_v_o), 64'd1);
        chk("postrst_err_o", 64'(err_o), 64'd0);
        pop_one();
        chk("postrst_one_ts", 64'(ts_v_o), 64'd0);

`ifdef BSG_MANYCORE_HOST_TIMER_DECODER_DELTA_EN
        do_reset();
        timer(32'd100, 4'd3, 4'd3); push_ts(64'd100, 4'd3, 4'd3); timer(32'd0, 4'd3, 4'd3);
        timer(32'd350, 4'd3, 4'd3); push_ts(64'd350, 4'd3, 4'd3); timer(32'd0, 4'd3, 4'd3);
        timer(32'd349, 4'd3, 4'd3); push_ts(64'd349, 4'd3, 4'd3); timer(32'd0, 4'd3, 4'd3);
        chk("delta_model_last", ts_q[2].delta, 64'hFFFF_FFFF_FFFF_FFFF);
        repeat (3) pop_one();
`else
        do_reset();
        chk("final_rst_ready_o", 64'(ready_o), 64'd1);
`endif

        idle(2);
        chk("byp_q_drained", 64'(byp_q.size()), 64'd0);
        chk("ts_q_drained", 64'(ts_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
